// File: rtl/cache_way_array.sv
// One cache way: tag/data arrays, per-set valid/dirty, registered tag compare and a flush/writeback engine.
// Define CACHE_WAY_TAG_PARITY_EN to store and check an even-parity bit alongside each tag.
module cache_way_array #(
  parameter int p_num_sets   = 8,
  parameter int p_tag_nbits  = 32,
  parameter int p_line_nbits = 128,
  localparam int IDX = $clog2(p_num_sets),
  localparam int BE  = p_line_nbits / 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    lookup_val,
  output logic                    lookup_rdy,
  input  logic [IDX-1:0]          lookup_idx,
  input  logic [p_tag_nbits-1:0]  lookup_tag,
  output logic                    resp_val,
  output logic                    resp_hit,
  output logic                    resp_dirty,
  output logic [p_tag_nbits-1:0]  resp_tag,
  output logic [p_line_nbits-1:0] resp_data,
  output logic                    parity_err,
  input  logic                    wr_en,
  input  logic [IDX-1:0]          wr_idx,
  input  logic [BE-1:0]           wr_byte_en,
  input  logic [p_line_nbits-1:0] wr_data,
  input  logic                    wr_set_dirty,
  input  logic                    fill_en,
  input  logic [IDX-1:0]          fill_idx,
  input  logic [p_tag_nbits-1:0]  fill_tag,
  input  logic [p_line_nbits-1:0] fill_data,
  input  logic                    flush_req,
  output logic                    flush_busy,
  output logic                    flush_done,
  output logic                    wb_val,
  input  logic                    wb_rdy,
  output logic [IDX-1:0]          wb_idx,
  output logic [p_tag_nbits-1:0]  wb_tag,
  output logic [p_line_nbits-1:0] wb_data
);

  typedef enum logic [1:0] {IDLE, SCAN, WB, DONE} flush_state_e;

  flush_state_e state_q, state_d;
  logic [IDX-1:0] s_q;

  logic [p_tag_nbits-1:0]  tag_mem  [p_num_sets];
  logic [p_line_nbits-1:0] data_mem [p_num_sets];
  logic [p_num_sets-1:0]   valid_q;
  logic [p_num_sets-1:0]   dirty_q;

  logic lookup_fire, fill_fire, wr_fire;
  logic s_dirty, last_set, s_step;
  logic look_valid, tag_eq, par_bad;
  logic [p_tag_nbits-1:0]  look_tag;
  logic [p_line_nbits-1:0] wr_merged;

  // Ready is held low during reset so nothing is accepted before the way is initialised.
  assign lookup_rdy  = ~flush_busy & ~reset;
  assign lookup_fire = lookup_val & lookup_rdy;
  assign fill_fire   = fill_en & ~flush_busy;
  assign wr_fire     = wr_en & ~flush_busy & valid_q[wr_idx] & ~(fill_fire && (fill_idx == wr_idx));

  assign s_dirty  = valid_q[s_q] & dirty_q[s_q];
  assign last_set = (s_q == IDX'(p_num_sets - 1));
  assign s_step   = ((state_q == SCAN) && !s_dirty) || ((state_q == WB) && wb_rdy);

  assign look_valid = valid_q[lookup_idx];
  assign look_tag   = tag_mem[lookup_idx];
  assign tag_eq     = (look_tag == lookup_tag);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE)
        s_q <= '0;
      else if (s_step)
        s_q <= s_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (flush_req) state_d = SCAN;
      SCAN: begin
        if (s_dirty)       state_d = WB;
        else if (last_set) state_d = DONE;
      end
      WB: begin
        if (wb_rdy) state_d = last_set ? DONE : SCAN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Writeback fields are zeroed outside WB so idle outputs read as 0.
  always_comb begin
    flush_busy = 1'b0;
    flush_done = 1'b0;
    wb_val     = 1'b0;
    wb_idx     = '0;
    wb_tag     = '0;
    wb_data    = '0;
    case (state_q)
      SCAN: flush_busy = 1'b1;
      WB: begin
        flush_busy = 1'b1;
        wb_val     = 1'b1;
        wb_idx     = s_q;
        wb_tag     = tag_mem[s_q];
        wb_data    = data_mem[s_q];
      end
      DONE: begin
        flush_busy = 1'b1;
        flush_done = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wr_merged = data_mem[wr_idx];
    for (int b = 0; b < BE; b++) begin
      if (wr_byte_en[b]) wr_merged[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (fill_fire) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= fill_data;
    end
    if (wr_fire) data_mem[wr_idx] <= wr_merged;
  end

`ifdef CACHE_WAY_TAG_PARITY_EN
  logic [p_num_sets-1:0] tag_par;
  logic resp_perr;

  assign par_bad    = look_valid & (tag_par[lookup_idx] != ^look_tag);
  assign parity_err = resp_perr;

  always_ff @(posedge clk) begin
    if (fill_fire) tag_par[fill_idx] <= ^fill_tag;
  end

  always_ff @(posedge clk) begin
    if (reset)
      resp_perr <= 1'b0;
    else if (lookup_fire)
      resp_perr <= par_bad;
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Fill is applied last so it overrides a parity invalidation of the same set.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (flush_busy) begin
      if (s_step) begin
        valid_q[s_q] <= 1'b0;
        dirty_q[s_q] <= 1'b0;
      end
    end else begin
      if (lookup_fire && par_bad) valid_q[lookup_idx] <= 1'b0;
      if (wr_fire && wr_set_dirty) dirty_q[wr_idx] <= 1'b1;
      if (fill_fire) begin
        valid_q[fill_idx] <= 1'b1;
        dirty_q[fill_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_val   <= 1'b0;
      resp_hit   <= 1'b0;
      resp_dirty <= 1'b0;
      resp_tag   <= '0;
      resp_data  <= '0;
    end else begin
      resp_val <= lookup_fire;
      if (lookup_fire) begin
        resp_hit   <= look_valid & tag_eq & ~par_bad;
        resp_dirty <= dirty_q[lookup_idx];
        resp_tag   <= look_tag;
        resp_data  <= data_mem[lookup_idx];
      end
    end
  end

endmodule

// File: tb/tb_cache_way_array.sv
// Directed self-checking bench for cache_way_array (default parameters: 8 sets, 32-bit tag, 128-bit line).
module tb_cache_way_array;

  localparam int NS = 8;
  localparam int TW = 32;
  localparam int LW = 128;
  localparam int IW = 3;
  localparam int BW = 16;

  logic          clk;
  logic          reset;
  logic          lookup_val;
  logic          lookup_rdy;
  logic [IW-1:0] lookup_idx;
  logic [TW-1:0] lookup_tag;
  logic          resp_val;
  logic          resp_hit;
  logic          resp_dirty;
  logic [TW-1:0] resp_tag;
  logic [LW-1:0] resp_data;
  logic          parity_err;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [BW-1:0] wr_byte_en;
  logic [LW-1:0] wr_data;
  logic          wr_set_dirty;
  logic          fill_en;
  logic [IW-1:0] fill_idx;
  logic [TW-1:0] fill_tag;
  logic [LW-1:0] fill_data;
  logic          flush_req;
  logic          flush_busy;
  logic          flush_done;
  logic          wb_val;
  logic          wb_rdy;
  logic [IW-1:0] wb_idx;
  logic [TW-1:0] wb_tag;
  logic [LW-1:0] wb_data;

  int total = 0;
  int bad   = 0;

  cache_way_array #(.p_num_sets(NS), .p_tag_nbits(TW), .p_line_nbits(LW)) dut (
    .clk(clk), .reset(reset),
    .lookup_val(lookup_val), .lookup_rdy(lookup_rdy), .lookup_idx(lookup_idx), .lookup_tag(lookup_tag),
    .resp_val(resp_val), .resp_hit(resp_hit), .resp_dirty(resp_dirty), .resp_tag(resp_tag),
    .resp_data(resp_data), .parity_err(parity_err),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_byte_en(wr_byte_en), .wr_data(wr_data), .wr_set_dirty(wr_set_dirty),
    .fill_en(fill_en), .fill_idx(fill_idx), .fill_tag(fill_tag), .fill_data(fill_data),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .wb_val(wb_val), .wb_rdy(wb_rdy), .wb_idx(wb_idx), .wb_tag(wb_tag), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge with the currently driven inputs; one-shot requests are then withdrawn.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    lookup_val = 1'b0;
    wr_en      = 1'b0;
    fill_en    = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [LW-1:0] observed, input logic [LW-1:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setLookup(input logic [IW-1:0] idx, input logic [TW-1:0] tag);
    lookup_val = 1'b1;
    lookup_idx = idx;
    lookup_tag = tag;
  endtask

  task automatic setFill(input logic [IW-1:0] idx, input logic [TW-1:0] tag, input logic [LW-1:0] data);
    fill_en   = 1'b1;
    fill_idx  = idx;
    fill_tag  = tag;
    fill_data = data;
  endtask

  task automatic setWrite(input logic [IW-1:0] idx, input logic [BW-1:0] be, input logic [LW-1:0] data,
                          input logic dirty);
    wr_en        = 1'b1;
    wr_idx       = idx;
    wr_byte_en   = be;
    wr_data      = data;
    wr_set_dirty = dirty;
  endtask

  logic [LW-1:0] line_a5, line_mix, line_11, line_77, line_99, line_w1, line_w5, line_d;

  initial begin
    line_a5  = {16{8'hA5}};
    line_mix = {{15{8'hA5}}, 8'h5A};
    line_11  = {16{8'h11}};
    line_77  = {16{8'h77}};
    line_99  = {16{8'h99}};
    line_w1  = {4{32'hC0DE_0001}};
    line_w5  = {4{32'hBEEF_0005}};
    line_d   = {16{8'h3C}};

    reset = 1'b1; lookup_val = 1'b0; lookup_idx = '0; lookup_tag = '0;
    wr_en = 1'b0; wr_idx = '0; wr_byte_en = '0; wr_data = '0; wr_set_dirty = 1'b0;
    fill_en = 1'b0; fill_idx = '0; fill_tag = '0; fill_data = '0;
    flush_req = 1'b0; wb_rdy = 1'b0;

    $display("[TB] reset");
    applyStimulus();
    applyStimulus();
    checkOutput("rst_lookup_rdy", LW'(lookup_rdy), LW'(0));
    checkOutput("rst_resp_val", LW'(resp_val), LW'(0));
    checkOutput("rst_resp_tag", LW'(resp_tag), LW'(0));
    checkOutput("rst_resp_data", resp_data, LW'(0));
    checkOutput("rst_flush_busy", LW'(flush_busy), LW'(0));
    checkOutput("rst_wb_val", LW'(wb_val), LW'(0));
    checkOutput("rst_wb_idx", LW'(wb_idx), LW'(0));
    reset = 1'b0;
    applyStimulus();
    checkOutput("post_rst_lookup_rdy", LW'(lookup_rdy), LW'(1));

    $display("[TB] fill and lookup");
    setFill(3'd3, 32'h1234, line_a5);
    applyStimulus();
    setLookup(3'd3, 32'h1234);
    applyStimulus();
    checkOutput("hit_val", LW'(resp_val), LW'(1));
    checkOutput("hit_hit", LW'(resp_hit), LW'(1));
    checkOutput("hit_dirty", LW'(resp_dirty), LW'(0));
    checkOutput("hit_data", resp_data, line_a5);
    checkOutput("hit_perr", LW'(parity_err), LW'(0));
    setLookup(3'd3, 32'h1235);
    applyStimulus();
    checkOutput("miss_val", LW'(resp_val), LW'(1));
    checkOutput("miss_hit", LW'(resp_hit), LW'(0));
    checkOutput("miss_victim_tag", LW'(resp_tag), LW'(32'h1234));
    applyStimulus();
    checkOutput("idle_resp_val", LW'(resp_val), LW'(0));

    $display("[TB] byte write");
    setWrite(3'd3, 16'h0001, {16{8'h5A}}, 1'b1);
    applyStimulus();
    setLookup(3'd3, 32'h1234);
    applyStimulus();
    checkOutput("wr_hit", LW'(resp_hit), LW'(1));
    checkOutput("wr_data", resp_data, line_mix);
    checkOutput("wr_dirty", LW'(resp_dirty), LW'(1));
    setWrite(3'd4, 16'hFFFF, line_99, 1'b1);
    applyStimulus();
    setLookup(3'd4, 32'h0);
    applyStimulus();
    checkOutput("inv_wr_hit", LW'(resp_hit), LW'(0));
    checkOutput("inv_wr_dirty", LW'(resp_dirty), LW'(0));

    $display("[TB] same-cycle fill/write/lookup");
    setFill(3'd2, 32'h22, line_11);
    applyStimulus();
    setFill(3'd2, 32'h33, line_77);
    setWrite(3'd2, 16'hFFFF, line_99, 1'b1);
    setLookup(3'd2, 32'h22);
    applyStimulus();
    checkOutput("coll_old_val", LW'(resp_val), LW'(1));
    checkOutput("coll_old_hit", LW'(resp_hit), LW'(1));
    checkOutput("coll_old_data", resp_data, line_11);
    setLookup(3'd2, 32'h33);
    applyStimulus();
    checkOutput("coll_new_val", LW'(resp_val), LW'(1));
    checkOutput("coll_new_hit", LW'(resp_hit), LW'(1));
    checkOutput("coll_new_data", resp_data, line_77);
    checkOutput("coll_new_dirty", LW'(resp_dirty), LW'(0));

    $display("[TB] flush with writebacks");
    setFill(3'd1, 32'h100, line_d);
    applyStimulus();
    setFill(3'd5, 32'h500, line_d);
    applyStimulus();
    setFill(3'd3, 32'h300, line_d);
    applyStimulus();
    setWrite(3'd1, 16'hFFFF, line_w1, 1'b1);
    applyStimulus();
    setWrite(3'd5, 16'hFFFF, line_w5, 1'b1);
    applyStimulus();
    flush_req = 1'b1;
    applyStimulus();
    flush_req = 1'b0;
    checkOutput("fl_s0_busy", LW'(flush_busy), LW'(1));
    checkOutput("fl_s0_rdy", LW'(lookup_rdy), LW'(0));
    checkOutput("fl_s0_wb", LW'(wb_val), LW'(0));
    applyStimulus();
    checkOutput("fl_s1_wb", LW'(wb_val), LW'(0));
    applyStimulus();
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("fl_wb1_val_c%0d", c), LW'(wb_val), LW'(1));
      checkOutput($sformatf("fl_wb1_idx_c%0d", c), LW'(wb_idx), LW'(1));
      checkOutput($sformatf("fl_wb1_tag_c%0d", c), LW'(wb_tag), LW'(32'h100));
      checkOutput($sformatf("fl_wb1_data_c%0d", c), wb_data, line_w1);
      if (c < 2) applyStimulus();
    end
    wb_rdy = 1'b1;
    applyStimulus();
    wb_rdy = 1'b0;
    checkOutput("fl_s2_wb", LW'(wb_val), LW'(0));
    applyStimulus();
    setLookup(3'd2, 32'h33);
    applyStimulus();
    checkOutput("fl_lookup_ignored", LW'(resp_val), LW'(0));
    checkOutput("fl_no_early_done", LW'(flush_done), LW'(0));
    applyStimulus();
    checkOutput("fl_s5_wb", LW'(wb_val), LW'(0));
    applyStimulus();
    checkOutput("fl_wb5_val", LW'(wb_val), LW'(1));
    checkOutput("fl_wb5_idx", LW'(wb_idx), LW'(5));
    checkOutput("fl_wb5_tag", LW'(wb_tag), LW'(32'h500));
    checkOutput("fl_wb5_data", wb_data, line_w5);
    wb_rdy = 1'b1;
    applyStimulus();
    wb_rdy = 1'b0;
    applyStimulus();
    checkOutput("fl_s7_done", LW'(flush_done), LW'(0));
    applyStimulus();
    checkOutput("fl_done", LW'(flush_done), LW'(1));
    checkOutput("fl_done_busy", LW'(flush_busy), LW'(1));
    applyStimulus();
    checkOutput("fl_after_done", LW'(flush_done), LW'(0));
    checkOutput("fl_after_busy", LW'(flush_busy), LW'(0));
    checkOutput("fl_after_rdy", LW'(lookup_rdy), LW'(1));
    setLookup(3'd1, 32'h100);
    applyStimulus();
    checkOutput("post_fl_s1_hit", LW'(resp_hit), LW'(0));
    checkOutput("post_fl_s1_dirty", LW'(resp_dirty), LW'(0));
    setLookup(3'd2, 32'h33);
    applyStimulus();
    checkOutput("post_fl_s2_hit", LW'(resp_hit), LW'(0));
    setLookup(3'd3, 32'h300);
    applyStimulus();
    checkOutput("post_fl_s3_hit", LW'(resp_hit), LW'(0));
    setLookup(3'd5, 32'h500);
    applyStimulus();
    checkOutput("post_fl_s5_hit", LW'(resp_hit), LW'(0));

    $display("[TB] reset during writeback");
    setFill(3'd6, 32'h600, line_d);
    applyStimulus();
    setWrite(3'd6, 16'h00FF, line_w1, 1'b1);
    applyStimulus();
    flush_req = 1'b1;
    applyStimulus();
    flush_req = 1'b0;
    for (int c = 0; c < 7; c++) applyStimulus();
    checkOutput("rwb_wb_val", LW'(wb_val), LW'(1));
    checkOutput("rwb_wb_idx", LW'(wb_idx), LW'(6));
    reset = 1'b1;
    applyStimulus();
    checkOutput("rwb_wb_dropped", LW'(wb_val), LW'(0));
    checkOutput("rwb_busy", LW'(flush_busy), LW'(0));
    checkOutput("rwb_done", LW'(flush_done), LW'(0));
    reset = 1'b0;
    applyStimulus();
    checkOutput("rwb_done_after", LW'(flush_done), LW'(0));
    setLookup(3'd6, 32'h600);
    applyStimulus();
    checkOutput("rwb_s6_val", LW'(resp_val), LW'(1));
    checkOutput("rwb_s6_hit", LW'(resp_hit), LW'(0));
    checkOutput("rwb_s6_dirty", LW'(resp_dirty), LW'(0));
    setLookup(3'd2, 32'h33);
    applyStimulus();
    checkOutput("rwb_s2_hit", LW'(resp_hit), LW'(0));

`ifdef CACHE_WAY_TAG_PARITY_EN
    $display("[TB] tag parity");
    setFill(3'd0, 32'h1, line_a5);
    applyStimulus();
    dut.tag_par[0] = ~dut.tag_par[0];
    setLookup(3'd0, 32'h1);
    applyStimulus();
    checkOutput("par_err", LW'(parity_err), LW'(1));
    checkOutput("par_hit", LW'(resp_hit), LW'(0));
    setLookup(3'd0, 32'h1);
    applyStimulus();
    checkOutput("par_rep_err", LW'(parity_err), LW'(0));
    checkOutput("par_rep_hit", LW'(resp_hit), LW'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
